mips_regfile_irst: RTL
======================

Name: mips_regfile_irst

Overview:
Parametrised successor to the mips_16 register file, adding a built-in register scan sequencer ("irst").
- Core side: DEPTH x WIDTH registers, one write port, NUM_RD combinational read ports, optional hard-zero R0, optional write-to-read bypass.
- irst side: after reset, or on request, a sequencer streams every register out one per cycle, then raises a sticky done flag. It can optionally zero each register as it passes (scrub mode).
- Sits beside the core pipeline. The irst stream feeds signature/trace logic (rand_data path).

Parameters:
WIDTH, 16, register width in bits
DEPTH, 8, number of registers; power of 2, >=2
NUM_RD, 2, number of read ports
ZERO_REG0, 1, 1 = R0 reads 0 and writes to R0 are dropped
BYPASS, 0, 1 = read of the address being written this cycle returns reg_write_data
AUTO_START, 1, 1 = scan starts automatically on the first clock after reset release
ADDR_W, $clog2(DEPTH), derived; not overridden

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
reg_write_en  in  1  core write enable
reg_write_dest  in  ADDR_W  core write address
reg_write_data  in  WIDTH  core write data
reg_read_addr  in  NUM_RD*ADDR_W  packed read addresses; port p = bits [p*ADDR_W +: ADDR_W]
reg_read_data  out  NUM_RD*WIDTH  packed read data, combinational
irst_start  in  1  pulse: start a scan
irst_scrub  in  1  mode, sampled with the start; 1 = zero each register after reading it
irst_busy  out  1  high while the scan is in SCAN state
irst_valid  out  1  irst_idx/irst_reg_data valid this cycle
irst_idx  out  ADDR_W  index of the register being output
irst_reg_data  out  WIDTH  register contents
irst_done  out  1  sticky scan-complete flag

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers 0; state IDLE; scan counter 0; scrub_mode 0.
  - irst_busy, irst_valid, irst_done = 0; irst_idx = 0; irst_reg_data = 0.
- Reads:
  - reg_read_data[p] = reg[addr_p], combinational.
  - If ZERO_REG0 and addr_p==0: returns 0. This overrides bypass.
  - If BYPASS, reg_write_en is high, the write is accepted and reg_write_dest==addr_p: returns reg_write_data.
  - Otherwise returns the stored value.
- Writes:
  - Take effect at the edge when reg_write_en=1 and irst_busy=0.
  - Write to R0 is dropped when ZERO_REG0=1.
  - Writes while irst_busy=1 are discarded (no queueing). Bypass is also inactive then.
- FSM, states IDLE, SCAN, DONE:
  - IDLE -> SCAN: on irst_start=1, or on the first edge after reset release when AUTO_START=1. Counter is cleared to 0; scrub_mode <= irst_scrub.
  - SCAN, counter k: at the edge, irst_valid<=1, irst_idx<=k, irst_reg_data<=reg[k] (pre-edge value; reads 0 for k=0 when ZERO_REG0). If scrub_mode, reg[k]<=0 at the same edge.
  - SCAN, k<DEPTH-1: k<=k+1.
  - SCAN, k==DEPTH-1: -> DONE and irst_done<=1 at the same edge.
  - In any state not SCAN: irst_valid<=0 at the edge.
  - irst_busy is high exactly in SCAN. Combinational from state, so it is high DEPTH cycles.
  - DONE -> SCAN: on irst_start (irst_done cleared at that edge; scrub sampled again).
  - DONE with no start: stays, irst_done held.
- Latency: the first irst_valid appears 1 edge after entering SCAN. A scan takes exactly DEPTH valid cycles, contiguous; irst_done rises with the last valid.
- irst_start while in SCAN is ignored; the scan is not restarted.
- Reset during SCAN aborts immediately to the reset values. The scan restarts after release only if AUTO_START=1.
- Counter wraps never; the terminal compare stops it at DEPTH-1.

Test Plan:
- Defaults, release reset, no other stimulus -> 8 contiguous irst_valid cycles, irst_idx 0..7, all data 0; irst_done rises with idx=7; irst_busy high 8 cycles.
- Scan done; write R1..R7 = 16'h1111*i; R0 write of 16'hFFFF; pulse irst_start, irst_scrub=0 -> stream 0000,1111,...,7777 (R0 is 0); read ports then still return 16'h3333 for R3.
- After the previous test, pulse irst_start with irst_scrub=1 -> same stream as previous test; afterwards every read port returns 0.
- Write R5=16'hBEEF at the edge SCAN begins and again mid-scan -> both writes dropped; R5 reads 0 after the scan.
- BYPASS=1, idle: write R2=16'hA5A5 with read_addr port1=2 in the same cycle -> port1 shows 16'hA5A5 before the edge. Port0 addr 0 with write to R0 -> port0 shows 0.
- Reset asserted at idx=3 -> outputs 0 asynchronously. AUTO_START=1: fresh scan idx 0..7 after release. AUTO_START=0: stays IDLE, irst_done=0 until irst_start.

Source files
------------

// File: rtl/mips_regfile_irst_if.sv
// mips_regfile_irst_if: bus bundle for the register file with scan sequencer.
//   Core write port : reg_write_en, reg_write_dest, reg_write_data
//   Core read ports : reg_read_addr (packed NUM_RD x ADDR_W), reg_read_data (packed NUM_RD x WIDTH)
//   Scan control    : irst_start, irst_scrub
//   Scan stream     : irst_busy, irst_valid, irst_idx, irst_reg_data, irst_done
// master drives the core/scan requests; slave is the register file.
interface mips_regfile_irst_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_RD = 2,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
);
    logic                     reg_write_en;
    logic [ADDR_W-1:0]        reg_write_dest;
    logic [WIDTH-1:0]         reg_write_data;
    logic [NUM_RD*ADDR_W-1:0] reg_read_addr;
    logic [NUM_RD*WIDTH-1:0]  reg_read_data;
    logic                     irst_start;
    logic                     irst_scrub;
    logic                     irst_busy;
    logic                     irst_valid;
    logic [ADDR_W-1:0]        irst_idx;
    logic [WIDTH-1:0]         irst_reg_data;
    logic                     irst_done;

    modport master (
        output reg_write_en, reg_write_dest, reg_write_data, reg_read_addr,
               irst_start, irst_scrub,
        input  reg_read_data, irst_busy, irst_valid, irst_idx, irst_reg_data, irst_done
    );

    modport slave (
        input  reg_write_en, reg_write_dest, reg_write_data, reg_read_addr,
               irst_start, irst_scrub,
        output reg_read_data, irst_busy, irst_valid, irst_idx, irst_reg_data, irst_done
    );
endinterface

// File: rtl/mips_regfile_irst.sv
// mips_regfile_irst: DEPTH x WIDTH register file with one write port, NUM_RD combinational
// read ports, optional hard-zero R0 and write-to-read bypass, plus a scan sequencer that
// streams every register out one per cycle and can optionally zero each one as it passes.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : mips_regfile_irst_if slave modport (write/read ports, scan control and stream)
module mips_regfile_irst #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG0  = 1,
    parameter int unsigned BYPASS     = 0,
    parameter int unsigned AUTO_START = 1,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                rst,
    mips_regfile_irst_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              scrub_q, scrub_d;
    logic              done_q, done_d;
    logic              auto_q;
    logic              valid_q;
    logic [ADDR_W-1:0] idx_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  regs_q [DEPTH];

    logic              busy;
    logic              wr_ok;
    logic              last;
    logic [WIDTH-1:0]  scan_data;

    assign busy  = (state_q == StScan);
    assign last  = (cnt_q == ADDR_W'(DEPTH - 1));
    // Core writes are simply discarded while a scan owns the array.
    assign wr_ok = bus.reg_write_en && !busy &&
                   !((ZERO_REG0 != 0) && (bus.reg_write_dest == '0));
    assign scan_data = ((ZERO_REG0 != 0) && (cnt_q == '0)) ? '0 : regs_q[cnt_q];

    // Read ports: R0 hard-zero wins over bypass, bypass only for accepted writes.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = bus.reg_read_addr[p*ADDR_W +: ADDR_W];
        assign bus.reg_read_data[p*WIDTH +: WIDTH] =
            ((ZERO_REG0 != 0) && (addr == '0))                       ? '0 :
            ((BYPASS != 0) && wr_ok && (bus.reg_write_dest == addr)) ? bus.reg_write_data :
                                                                      regs_q[addr];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scrub_d = scrub_q;
        done_d  = done_q;
        case (state_q)
            StIdle: begin
                // auto_q is only set for the first edge after reset release.
                if (bus.irst_start || auto_q) begin
                    state_d = StScan;
                    cnt_d   = '0;
                    scrub_d = bus.irst_scrub;
                end
            end
            StScan: begin
                if (last) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.irst_start) begin
                    state_d = StScan;
                    cnt_d   = '0;
                    scrub_d = bus.irst_scrub;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            scrub_q <= 1'b0;
            done_q  <= 1'b0;
            auto_q  <= (AUTO_START != 0);
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scrub_q <= scrub_d;
            done_q  <= done_d;
            auto_q  <= 1'b0;
            valid_q <= busy;
            if (busy) begin
                idx_q  <= cnt_q;
                data_q <= scan_data;
            end
        end
    end

    // Scrub and core write never coincide: core writes require !busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                regs_q[bus.reg_write_dest] <= bus.reg_write_data;
            end
            if (busy && scrub_q) begin
                regs_q[cnt_q] <= '0;
            end
        end
    end

    assign bus.irst_busy     = busy;
    assign bus.irst_valid    = valid_q;
    assign bus.irst_idx      = idx_q;
    assign bus.irst_reg_data = data_q;
    assign bus.irst_done     = done_q;

endmodule
